pc_sequencer: RTL and testbench

//   Program-flow controller for the instruction memory: owns the 4-bit PC, presents it as im_addr,
//   and sequences start/run/stall/halt, branches and (optionally) subroutine call/return.

---
 rtl/pc_seq_pkg.sv | 14 +
 rtl/pc_seq_ret_stack.sv | 48 ++++
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StHalt = 2'b10
   } pc_seq_state_e;

   localparam int unsigned PC_ADDR_W      = 4;
   localparam int unsigned PC_RESET_ADDR  = 0;
   localparam int unsigned PC_STACK_DEPTH = 4;

endpackage

// File: rtl/pc_seq_ret_stack.sv
// Return-address LIFO for subroutine call/return. Pushes while full and pops while empty
// are ignored; the caller flags those as errors.
module pc_seq_ret_stack #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] top,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CntW-1:0]  cnt_q;
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;

   assign wr_ptr = PtrW'(cnt_q);
   assign rd_ptr = PtrW'(cnt_q - CntW'(1));
   assign full   = (cnt_q == CntW'(DEPTH));
   assign empty  = (cnt_q == '0);
   assign top    = mem_q[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (push && !full) begin
         cnt_q <= cnt_q + CntW'(1);
      end else if (pop && !empty) begin
         cnt_q <= cnt_q - CntW'(1);
      end
   end

   // Storage needs no reset: entries are only read below the fill count.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem_q[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-flow controller: owns the PC driving instruction memory, sequences start/run/halt,
// branches and, when PC_SEQ_CALL_STACK_EN is defined, subroutine call/return.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned ADDR_W      = PC_ADDR_W,
   parameter int unsigned RESET_ADDR  = PC_RESET_ADDR,
   parameter int unsigned STACK_DEPTH = PC_STACK_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stall,
   input  logic              halt_req,
   input  logic              branch_en,
   input  logic [ADDR_W-1:0] branch_addr,
   input  logic              call_en,
   input  logic              ret_en,
   output logic [ADDR_W-1:0] im_addr,
   output logic              instr_valid,
   output logic              halted,
   output logic              stack_err
);

   localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_ADDR);

   pc_seq_state_e     state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_inc;

   assign pc_inc      = pc_q + ADDR_W'(1);
   assign im_addr     = pc_q;
   assign instr_valid = (state_q == StRun) && !stall;
   assign halted      = (state_q == StHalt);

`ifdef PC_SEQ_CALL_STACK_EN
   logic              push, pop;
   logic              stk_full, stk_empty;
   logic [ADDR_W-1:0] stk_top;
   logic              err_set, err_q;

   pc_seq_ret_stack #(
      .WIDTH (ADDR_W),
      .DEPTH (STACK_DEPTH)
   ) u_ret_stack (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .top   (stk_top),
      .full  (stk_full),
      .empty (stk_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end
   end

   assign stack_err = err_q;
`else
   logic unused_ret;
   localparam int unsigned unused_depth = STACK_DEPTH;

   assign unused_ret = ret_en;
   assign stack_err  = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
`ifdef PC_SEQ_CALL_STACK_EN
      push    = 1'b0;
      pop     = 1'b0;
      err_set = 1'b0;
`endif
      case (state_q)
         StIdle, StHalt: begin
            if (start) begin
               state_d = StRun;
               pc_d    = ResetPc;
            end
         end
         StRun: begin
            // Flow controls only matter on cycles that actually execute an instruction.
            if (!stall) begin
               if (halt_req) begin
                  state_d = StHalt;
`ifdef PC_SEQ_CALL_STACK_EN
               end else if (ret_en) begin
                  if (stk_empty) begin
                     pc_d    = pc_inc;
                     err_set = 1'b1;
                  end else begin
                     pc_d = stk_top;
                     pop  = 1'b1;
                  end
               end else if (call_en) begin
                  pc_d = branch_addr;
                  if (stk_full) begin
                     err_set = 1'b1;
                  end else begin
                     push = 1'b1;
                  end
               end else if (branch_en) begin
                  pc_d = branch_addr;
`else
               end else if (call_en || branch_en) begin
                  pc_d = branch_addr;
`endif
               end else begin
                  pc_d = pc_inc;
               end
            end
         end
         default: begin
            state_d = StIdle;
            pc_d    = ResetPc;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pc_q    <= ResetPc;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized flow checked against a
// queue-based reference model. Stack scenarios follow PC_SEQ_CALL_STACK_EN.
module tb_pc_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start, stall, halt_req, branch_en, call_en, ret_en;
   logic [3:0] branch_addr;
   logic [3:0] im_addr;
   logic       instr_valid, halted, stack_err;

   int nchk = 0;
   int nerr = 0;

   // Reference model state
   bit m_run, m_halt, m_err;
   int m_pc;
   int m_stk[$];

   pc_sequencer #(
      .ADDR_W      (4),
      .RESET_ADDR  (0),
      .STACK_DEPTH (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stall       (stall),
      .halt_req    (halt_req),
      .branch_en   (branch_en),
      .branch_addr (branch_addr),
      .call_en     (call_en),
      .ret_en      (ret_en),
      .im_addr     (im_addr),
      .instr_valid (instr_valid),
      .halted      (halted),
      .stack_err   (stack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_in();
      start = 0; stall = 0; halt_req = 0; branch_en = 0; call_en = 0; ret_en = 0;
      branch_addr = '0;
   endtask

   task automatic model_reset();
      m_run = 0; m_halt = 0; m_err = 0; m_pc = 0;
      m_stk.delete();
   endtask

   task automatic model_step();
      if (!m_run) begin
         if (start) begin
            m_run = 1; m_halt = 0; m_pc = 0;
         end
      end else if (!stall) begin
         if (halt_req) begin
            m_run = 0; m_halt = 1;
`ifdef PC_SEQ_CALL_STACK_EN
         end else if (ret_en) begin
            if (m_stk.size() == 0) begin
               m_err = 1; m_pc = (m_pc + 1) % 16;
            end else begin
               m_pc = m_stk.pop_back();
            end
         end else if (call_en) begin
            if (m_stk.size() == 4) m_err = 1;
            else m_stk.push_back((m_pc + 1) % 16);
            m_pc = int'(branch_addr);
         end else if (branch_en) begin
            m_pc = int'(branch_addr);
`else
         end else if (call_en || branch_en) begin
            m_pc = int'(branch_addr);
`endif
         end else begin
            m_pc = (m_pc + 1) % 16;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 0;
      clear_in();
      model_reset();
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic run_to(input int n);
      start = 1; tick(); start = 0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      @(posedge clk);
      #2;
      rst_n = 0;
      clear_in();
      model_reset();
      #1;
      nchk++; if (im_addr !== 4'd0) begin nerr++; $display("FAIL reset_pc got %0d exp 0", im_addr); end
      nchk++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
      nchk++; if (halted !== 1'b0) begin nerr++; $display("FAIL reset_halted got %b exp 0", halted); end
      nchk++; if (stack_err !== 1'b0) begin nerr++; $display("FAIL reset_err got %b exp 0", stack_err); end
      @(negedge clk);
      rst_n = 1;
      branch_en = 1; branch_addr = 4'd6;
      tick(); tick();
      branch_en = 0;
      nchk++; if (im_addr !== 4'd0 || instr_valid !== 1'b0)
         begin nerr++; $display("FAIL idle_hold got pc=%0d v=%b exp pc=0 v=0", im_addr, instr_valid); end
   endtask

   task automatic test_count();
      do_reset();
      start = 1; tick(); start = 0;
      for (int i = 0; i < 18; i++) begin
         nchk++;
         if (im_addr !== 4'(i % 16) || instr_valid !== 1'b1) begin
            nerr++;
            $display("FAIL count[%0d] got pc=%0d v=%b exp pc=%0d v=1", i, im_addr, instr_valid, i % 16);
         end
         tick();
      end
   endtask

   task automatic test_branch();
      do_reset();
      run_to(3);
      nchk++; if (im_addr !== 4'd3) begin nerr++; $display("FAIL br_pre got %0d exp 3", im_addr); end
      branch_en = 1; branch_addr = 4'd9; stall = 1;
      #1;
      nchk++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL br_stall_valid got %b exp 0", instr_valid); end
      tick();
      nchk++; if (im_addr !== 4'd3) begin nerr++; $display("FAIL br_stall_pc got %0d exp 3", im_addr); end
      stall = 0;
      tick();
      nchk++; if (im_addr !== 4'd9) begin nerr++; $display("FAIL br_take got %0d exp 9", im_addr); end
      branch_en = 0;
      tick();
      nchk++; if (im_addr !== 4'd10) begin nerr++; $display("FAIL br_after got %0d exp 10", im_addr); end
   endtask

   task automatic test_halt();
      do_reset();
      run_to(5);
      halt_req = 1; branch_en = 1; branch_addr = 4'd2;
      tick();
      clear_in();
      nchk++; if (halted !== 1'b1 || im_addr !== 4'd5 || instr_valid !== 1'b0) begin
         nerr++; $display("FAIL halt got h=%b pc=%0d v=%b exp h=1 pc=5 v=0", halted, im_addr, instr_valid);
      end
      branch_en = 1; call_en = 1; branch_addr = 4'd1;
      tick(); tick(); tick();
      clear_in();
      nchk++; if (halted !== 1'b1 || im_addr !== 4'd5) begin
         nerr++; $display("FAIL halt_hold got h=%b pc=%0d exp h=1 pc=5", halted, im_addr);
      end
      start = 1; tick(); start = 0;
      nchk++; if (halted !== 1'b0 || im_addr !== 4'd0 || instr_valid !== 1'b1) begin
         nerr++; $display("FAIL restart got h=%b pc=%0d v=%b exp h=0 pc=0 v=1", halted, im_addr, instr_valid);
      end
      tick();
      start = 1; tick(); start = 0;
      nchk++; if (im_addr !== 4'd2) begin nerr++; $display("FAIL start_in_run got %0d exp 2", im_addr); end
   endtask

`ifdef PC_SEQ_CALL_STACK_EN
   task automatic test_call();
      int exp_ret[4] = '{11, 10, 9, 4};
      do_reset();
      run_to(2);
      call_en = 1; branch_addr = 4'd12; tick(); call_en = 0;
      nchk++; if (im_addr !== 4'd12) begin nerr++; $display("FAIL call got %0d exp 12", im_addr); end
      tick();
      ret_en = 1; tick(); ret_en = 0;
      nchk++; if (im_addr !== 4'd3 || stack_err !== 1'b0) begin
         nerr++; $display("FAIL ret got pc=%0d e=%b exp pc=3 e=0", im_addr, stack_err);
      end
      for (int k = 0; k < 5; k++) begin
         call_en = 1; branch_addr = 4'(8 + k); tick();
         nchk++; if (im_addr !== 4'(8 + k) || stack_err !== (k == 4)) begin
            nerr++; $display("FAIL nest[%0d] got pc=%0d e=%b exp pc=%0d e=%0d", k, im_addr, stack_err, 8 + k, k == 4);
         end
      end
      call_en = 0; ret_en = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         nchk++; if (im_addr !== 4'(exp_ret[k])) begin
            nerr++; $display("FAIL unwind[%0d] got %0d exp %0d", k, im_addr, exp_ret[k]);
         end
      end
      tick(); ret_en = 0;
      nchk++; if (im_addr !== 4'd5 || stack_err !== 1'b1) begin
         nerr++; $display("FAIL unwind_empty got pc=%0d e=%b exp pc=5 e=1", im_addr, stack_err);
      end
   endtask

   task automatic test_empty_ret();
      do_reset();
      run_to(7);
      ret_en = 1; tick(); ret_en = 0;
      nchk++; if (im_addr !== 4'd8 || stack_err !== 1'b1) begin
         nerr++; $display("FAIL empty_ret got pc=%0d e=%b exp pc=8 e=1", im_addr, stack_err);
      end
      for (int i = 0; i < 4; i++) tick();
      nchk++; if (stack_err !== 1'b1) begin nerr++; $display("FAIL err_sticky got %b exp 1", stack_err); end
      do_reset();
      nchk++; if (stack_err !== 1'b0) begin nerr++; $display("FAIL err_clear got %b exp 0", stack_err); end
   endtask
`else
   task automatic test_call();
      do_reset();
      run_to(2);
      call_en = 1; branch_addr = 4'd12; tick(); call_en = 0;
      nchk++; if (im_addr !== 4'd12) begin nerr++; $display("FAIL plain_call got %0d exp 12", im_addr); end
      ret_en = 1; tick(); ret_en = 0;
      nchk++; if (im_addr !== 4'd13 || stack_err !== 1'b0) begin
         nerr++; $display("FAIL ret_ignored got pc=%0d e=%b exp pc=13 e=0", im_addr, stack_err);
      end
   endtask

   task automatic test_empty_ret();
      do_reset();
      run_to(7);
      ret_en = 1; tick(); ret_en = 0;
      nchk++; if (im_addr !== 4'd8 || stack_err !== 1'b0) begin
         nerr++; $display("FAIL noret got pc=%0d e=%b exp pc=8 e=0", im_addr, stack_err);
      end
   endtask
`endif

   task automatic test_async_reset();
      do_reset();
      run_to(10);
      branch_en = 1; branch_addr = 4'd4;
      #2;
      rst_n = 0;
      #1;
      nchk++; if (im_addr !== 4'd0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
         nerr++; $display("FAIL async_rst got pc=%0d v=%b h=%b exp pc=0 v=0 h=0", im_addr, instr_valid, halted);
      end
      @(negedge clk);
      rst_n = 1;
      clear_in();
      model_reset();
      tick();
      nchk++; if (im_addr !== 4'd0 || instr_valid !== 1'b0) begin
         nerr++; $display("FAIL post_rst got pc=%0d v=%b exp pc=0 v=0", im_addr, instr_valid);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         start       = ($urandom % 8) == 0;
         stall       = ($urandom % 5) == 0;
         halt_req    = ($urandom % 20) == 0;
         branch_en   = ($urandom % 4) == 0;
         call_en     = ($urandom % 6) == 0;
         ret_en      = ($urandom % 6) == 0;
         branch_addr = 4'($urandom_range(0, 15));
         #1;
         nchk++;
         if (im_addr !== 4'(m_pc) || instr_valid !== (m_run && !stall) || halted !== m_halt ||
             stack_err !== m_err) begin
            nerr++;
            $display("FAIL rand[%0d] got pc=%0d v=%b h=%b e=%b exp pc=%0d v=%b h=%b e=%b", i, im_addr,
                     instr_valid, halted, stack_err, m_pc, m_run && !stall, m_halt, m_err);
         end
         tick();
      end
      clear_in();
   endtask

   initial begin
      rst_n = 0;
      clear_in();
      model_reset();
      test_reset();
      test_count();
      test_branch();
      test_halt();
      test_call();
      test_empty_ret();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
